// File: rtl/gtfwizard_raw_link_monitor.sv
// Multi-channel PRBS link-qualification monitor for the GTF raw example design.
// Debounces per-channel link status, tracks link losses and runs a timed bring-up verdict.
module gtfwizard_raw_link_monitor #(
  parameter int                     NUM_CHANNEL    = 1,
  parameter int                     STABLE_CYCLES  = 2048,
  parameter int                     TIMEOUT_CYCLES = 3000000,
  parameter int                     LOSS_CNT_WIDTH = 8,
  parameter logic [NUM_CHANNEL-1:0] CHANNEL_MASK   = {NUM_CHANNEL{1'b1}}
) (
  input  logic                                   freerun_clk,
  input  logic                                   hb_gtwiz_reset_all_in,
  input  logic [NUM_CHANNEL-1:0]                 link_status_in,
  input  logic [NUM_CHANNEL-1:0]                 link_down_latched_reset_in,
  input  logic                                   start_in,
  output logic [NUM_CHANNEL-1:0]                 link_stable_out,
  output logic [NUM_CHANNEL-1:0]                 link_down_latched_out,
  output logic [LOSS_CNT_WIDTH*NUM_CHANNEL-1:0]  link_loss_cnt_out,
  output logic                                   all_stable_out,
  output logic                                   timeout_out,
  output logic [1:0]                             state_out
);

  // state     | meaning
  // CH_DOWN   | last sample low, run counter cleared
  // CH_QUAL   | counting consecutive high samples
  // CH_STABLE | STABLE_CYCLES high samples seen, link qualified
  // V_IDLE    | no bring-up window open
  // V_WAIT    | window open, waiting for all masked channels stable
  // V_PASS    | all masked channels reached stable inside the window
  // V_FAIL    | window expired, or a masked channel dropped after PASS

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0]          RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]          TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_MAX = '1;

  typedef enum logic [1:0] {
    CH_DOWN   = 2'd0,
    CH_QUAL   = 2'd1,
    CH_STABLE = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_WAIT = 2'd1,
    V_PASS = 2'd2,
    V_FAIL = 2'd3
  } v_state_t;

  logic [NUM_CHANNEL-1:0] loss_event;

  for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_ch
    ch_state_t                 ch_state, ch_state_nxt;
    logic [RUN_W-1:0]          run_cnt, run_cnt_nxt;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt, loss_cnt_nxt;
    logic                      latched, latched_nxt;

    assign loss_event[i] = (ch_state == CH_STABLE) && !link_status_in[i];

    always_comb begin
      ch_state_nxt = ch_state;
      run_cnt_nxt  = run_cnt;
      if (!link_status_in[i]) begin
        ch_state_nxt = CH_DOWN;
        run_cnt_nxt  = '0;
      end else if (ch_state != CH_STABLE) begin
        run_cnt_nxt  = run_cnt + RUN_W'(1);
        ch_state_nxt = (run_cnt == RUN_LAST) ? CH_STABLE : CH_QUAL;
      end
    end

    // A clear coinciding with a loss keeps that loss, so the counter restarts at one.
    always_comb begin
      loss_cnt_nxt = loss_cnt;
      if (link_down_latched_reset_in[i])
        loss_cnt_nxt = loss_event[i] ? LOSS_CNT_WIDTH'(1) : '0;
      else if (loss_event[i] && (loss_cnt != LOSS_MAX))
        loss_cnt_nxt = loss_cnt + LOSS_CNT_WIDTH'(1);
    end

    always_comb begin
      latched_nxt = latched;
      if (!link_status_in[i])
        latched_nxt = 1'b1;
      else if (link_down_latched_reset_in[i])
        latched_nxt = 1'b0;
    end

    always_ff @(posedge freerun_clk) begin
      if (hb_gtwiz_reset_all_in) begin
        ch_state <= CH_DOWN;
        run_cnt  <= '0;
        loss_cnt <= '0;
        latched  <= 1'b1;
      end else begin
        ch_state <= ch_state_nxt;
        run_cnt  <= run_cnt_nxt;
        loss_cnt <= loss_cnt_nxt;
        latched  <= latched_nxt;
      end
    end

    assign link_stable_out[i]       = (ch_state == CH_STABLE);
    assign link_down_latched_out[i] = latched;
    assign link_loss_cnt_out[LOSS_CNT_WIDTH*i +: LOSS_CNT_WIDTH] = loss_cnt;
  end

  always_ff @(posedge freerun_clk) begin
    if (hb_gtwiz_reset_all_in)
      all_stable_out <= 1'b0;
    else
      all_stable_out <= (CHANNEL_MASK != '0) && (&(link_stable_out | ~CHANNEL_MASK));
  end

  v_state_t         v_state, v_state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             timeout_nxt;

  always_comb begin
    v_state_nxt = v_state;
    timer_nxt   = timer;
    timeout_nxt = timeout_out;
    case (v_state)
      V_IDLE: begin
        if (start_in) begin
          v_state_nxt = V_WAIT;
          timer_nxt   = '0;
          timeout_nxt = 1'b0;
        end
      end
      V_WAIT: begin
        timer_nxt = timer + TMR_W'(1);
        if (all_stable_out) begin
          v_state_nxt = V_PASS;
        end else if (timer == TMR_LAST) begin
          v_state_nxt = V_FAIL;
          timeout_nxt = 1'b1;
        end
      end
      V_PASS: begin
        if (start_in) begin
          v_state_nxt = V_WAIT;
          timer_nxt   = '0;
          timeout_nxt = 1'b0;
        end else if (|(loss_event & CHANNEL_MASK)) begin
          v_state_nxt = V_FAIL;
        end
      end
      V_FAIL: begin
        if (start_in) begin
          v_state_nxt = V_WAIT;
          timer_nxt   = '0;
          timeout_nxt = 1'b0;
        end
      end
      default: v_state_nxt = V_IDLE;
    endcase
  end

  always_ff @(posedge freerun_clk) begin
    if (hb_gtwiz_reset_all_in) begin
      v_state     <= V_IDLE;
      timer       <= '0;
      timeout_out <= 1'b0;
    end else begin
      v_state     <= v_state_nxt;
      timer       <= timer_nxt;
      timeout_out <= timeout_nxt;
    end
  end

  assign state_out = v_state;

endmodule

// File: tb/tb_gtfwizard_raw_link_monitor.sv
// Scoreboard bench for gtfwizard_raw_link_monitor: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them against the outputs of that cycle.
module tb_gtfwizard_raw_link_monitor;

  localparam int NCH = 4;
  localparam int LW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ls;
  logic [NCH-1:0]   clr;
  logic             start;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   latched;
  logic [LW*NCH-1:0] loss;
  logic             all_stable;
  logic             timeout;
  logic [1:0]       state;

  gtfwizard_raw_link_monitor #(
    .NUM_CHANNEL   (NCH),
    .STABLE_CYCLES (16),
    .TIMEOUT_CYCLES(100),
    .LOSS_CNT_WIDTH(LW),
    .CHANNEL_MASK  (4'b0111)
  ) dut (
    .freerun_clk               (clk),
    .hb_gtwiz_reset_all_in     (rst),
    .link_status_in            (ls),
    .link_down_latched_reset_in(clr),
    .start_in                  (start),
    .link_stable_out           (stable),
    .link_down_latched_out     (latched),
    .link_loss_cnt_out         (loss),
    .all_stable_out            (all_stable),
    .timeout_out               (timeout),
    .state_out                 (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_STABLE = 0, S_LATCH = 1, S_LOSS = 2, S_ALL = 3, S_TMO = 4, S_STATE = 5;

  typedef struct {
    int          cyc;
    int          id;
    int          ch;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic want(input int c, input int id, input int ch, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.id = id; e.ch = ch; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int id, input int ch);
    case (id)
      S_STABLE: return 32'(stable);
      S_LATCH:  return 32'(latched);
      S_LOSS:   return 32'(loss[ch*LW +: LW]);
      S_ALL:    return 32'(all_stable);
      S_TMO:    return 32'(timeout);
      default:  return 32'(state);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] act;
        act = observe(sb[i].id, sb[i].ch);
        checks++;
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %0h expected %0h", sb[i].name, sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic want_reset(input int c, input string tag);
    want(c, S_STABLE, 0, 0,     {tag, "_stable"});
    want(c, S_LATCH,  0, 4'hF,  {tag, "_latched"});
    want(c, S_LOSS,   0, 0,     {tag, "_loss0"});
    want(c, S_LOSS,   2, 0,     {tag, "_loss2"});
    want(c, S_ALL,    0, 0,     {tag, "_all_stable"});
    want(c, S_TMO,    0, 0,     {tag, "_timeout"});
    want(c, S_STATE,  0, 0,     {tag, "_state"});
  endtask

  initial begin
    int cs;
    rst = 1'b1; ls = '0; clr = '0; start = 1'b0;

    want_reset(1, "reset");
    to_cycle(1);

    // Qualification: ch1/ch2 high from edge 2; ch0 high 15, low at 17, high again 18..33.
    rst = 1'b0; ls = 4'b0111;
    want(16, S_STABLE, 0, 4'b0000, "t2_not_yet");
    want(17, S_STABLE, 0, 4'b0110, "t2_ch12_stable");
    want(32, S_STABLE, 0, 4'b0110, "t1_ch0_edge15");
    want(33, S_STABLE, 0, 4'b0111, "t1_ch0_edge16");
    want(33, S_ALL,    0, 0,       "t1_all_prev");
    want(34, S_ALL,    0, 1,       "t1_all_next");
    want(34, S_LOSS,   0, 0,       "t2_loss0");
    want(34, S_LATCH,  0, 4'hF,    "t2_latched");
    to_cycle(16); ls = 4'b0110;
    to_cycle(17); ls = 4'b0111;

    // Clear latched flags, then glitch ch0.
    to_cycle(34); clr = 4'b0111;
    want(35, S_LATCH,  0, 4'b1000, "t3_cleared");
    want(36, S_STABLE, 0, 4'b0111, "t3_pre_glitch");
    want(37, S_STABLE, 0, 4'b0110, "t3_drop_same_edge");
    want(37, S_LOSS,   0, 1,       "t3_loss1");
    want(37, S_LATCH,  0, 4'b1001, "t3_latched");
    want(52, S_STABLE, 0, 4'b0110, "t3_requal_15");
    want(53, S_STABLE, 0, 4'b0111, "t3_requal_16");
    to_cycle(35); clr = '0;
    to_cycle(36); ls = 4'b0110;
    to_cycle(37); ls = 4'b0111;

    // Clear coinciding with a loss, then clear alone.
    want(55, S_LOSS,  0, 1,       "clr_with_loss");
    want(55, S_LATCH, 0, 4'b1001, "clr_with_low");
    want(56, S_LOSS,  0, 0,       "clr_alone");
    want(56, S_LATCH, 0, 4'b1000, "clr_alone_latched");
    to_cycle(54); clr = 4'b0001; ls = 4'b0110;
    to_cycle(55); ls = 4'b0111;
    to_cycle(56); clr = '0;

    // Timeout: links dropped, window opened at edge 76, expires at edge 176.
    want(73, S_LOSS,   0, 1, "t4_loss0");
    want(73, S_LOSS,   1, 1, "t4_loss1");
    want(76, S_STATE,  0, 1, "t4_wait");
    want(76, S_TMO,    0, 0, "t4_tmo_low");
    want(120, S_STATE, 0, 1, "t4_start_ignored");
    want(175, S_STATE, 0, 1, "t4_wait_last");
    want(175, S_TMO,   0, 0, "t4_tmo_last");
    want(176, S_STATE, 0, 3, "t4_fail");
    want(176, S_TMO,   0, 1, "t4_tmo_set");
    to_cycle(72); ls = 4'b0000;
    to_cycle(75); start = 1'b1;
    to_cycle(76); start = 1'b0;
    to_cycle(119); start = 1'b1;
    to_cycle(120); start = 1'b0;

    // Pass with ch3 unmasked, unmasked drop ignored, masked drop fails.
    to_cycle(176); ls = 4'b1111;
    want(181, S_STATE,  0, 1,       "t5_restart");
    want(181, S_TMO,    0, 0,       "t5_tmo_cleared");
    want(192, S_STABLE, 0, 4'b1111, "t5_all_ch_stable");
    want(192, S_ALL,    0, 0,       "t5_all_prev");
    want(193, S_ALL,    0, 1,       "t5_all");
    want(193, S_STATE,  0, 1,       "t5_still_wait");
    want(194, S_STATE,  0, 2,       "t5_pass");
    want(197, S_STATE,  0, 2,       "t5_unmasked_drop");
    want(197, S_LOSS,   3, 1,       "t5_loss3");
    want(200, S_STATE,  0, 2,       "t5_pass_hold");
    want(201, S_STATE,  0, 3,       "t5_loss_fail");
    want(201, S_TMO,    0, 0,       "t5_tmo_low");
    want(201, S_STABLE, 0, 4'b0101, "t5_stable");
    want(201, S_LOSS,   1, 2,       "t5_loss1");
    to_cycle(180); start = 1'b1;
    to_cycle(181); start = 1'b0;
    to_cycle(196); ls = 4'b0111;
    to_cycle(200); ls = 4'b0101;

    // 260 losses on ch2 (counter was 1).
    to_cycle(202);
    for (int k = 0; k < 260; k++) begin
      int e;
      e = cyc + 1;
      if (k == 0)   want(e,     S_LOSS, 2, 2,   "t6_loss_first");
      if (k == 253) want(e - 1, S_LOSS, 2, 254, "t6_loss_254");
      if (k == 253) want(e,     S_LOSS, 2, 255, "t6_loss_255");
      if (k == 259) want(e,     S_LOSS, 2, 255, "t6_loss_sat");
      ls[2] = 1'b0;
      to_cycle(e);
      ls[2] = 1'b1;
      to_cycle(e + 16);
    end

    // Reset in the middle of a WAIT window.
    cs = cyc;
    want(cs + 1,  S_STATE, 0, 1,   "t6_wait");
    want(cs + 10, S_LOSS,  2, 255, "t6_loss_pre_reset");
    want(cs + 10, S_STATE, 0, 1,   "t6_wait_pre_reset");
    want_reset(cs + 11, "midreset");
    start = 1'b1;
    to_cycle(cs + 1); start = 1'b0;
    to_cycle(cs + 10); rst = 1'b1;
    to_cycle(cs + 11); rst = 1'b0;
    to_cycle(cs + 14);

    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: never checked, expected %0h at cycle %0d", sb[i].name, sb[i].val, sb[i].cyc);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
